// File: rtl/irq_pkg.sv
// irq_pkg: shared constants for the CP0 interrupt front-end.
// Register map, bit positions of the timer and external lines in the
// interrupts vector, and the number of external lines.
package irq_pkg;

  localparam logic [1:0] IRQ_MODE    = 2'd0;
  localparam logic [1:0] IRQ_MASK    = 2'd1;
  localparam logic [1:0] IRQ_PENDING = 2'd2;
  localparam logic [1:0] IRQ_RAW     = 2'd3;

  localparam int IRQ_TIMER_BIT = 0;
  localparam int IRQ_EXT_BASE  = 1;
  localparam int NUM_EXT_IRQ   = 7;

endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: configuration port between the CP0 glue (master)
// and the interrupt controller (slave). Reads are combinational from cfg_addr.
interface interrupt_controller_if;

  logic       cfg_write;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;

  modport master (
    output cfg_write,
    output cfg_addr,
    output cfg_wdata,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_write,
    input  cfg_addr,
    input  cfg_wdata,
    output cfg_rdata
  );

endinterface

// File: rtl/irq_sync.sv
// irq_sync: SYNC_STAGES-deep flop chain bringing one asynchronous line into
// the clk domain. SYNC_STAGES must be 2 or more.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw line through the chain; reset empties it immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: interrupt front-end for CP0.
// Synchronises seven external lines, captures them per line as level or
// rising edge, masks them, and produces the count/compare timer interrupt on
// bit 0. Define TIMER_INT_EN to build the timer; without it bit 0 is tied
// off everywhere and no comparator exists.
module interrupt_controller
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_EXT_IRQ-1:0] ext_irq,
  input  logic [31:0]            count,
  input  logic [31:0]            compare,
  input  logic                   compare_write,
  interrupt_controller_if.slave  cfg,
  output logic [7:0]             interrupts
);

  logic [NUM_EXT_IRQ-1:0] sync_level;
  logic [NUM_EXT_IRQ-1:0] sync_prev;
  logic [NUM_EXT_IRQ-1:0] rise;
  logic [NUM_EXT_IRQ-1:0] w1c_ext;
  logic [NUM_EXT_IRQ-1:0] mode_ext;
  logic [NUM_EXT_IRQ-1:0] pending_ext;
  logic [7:0]             mask_q;
  logic [7:0]             mask_rd;
  logic [7:0]             pending_all;
  logic                   pending_timer;
  logic                   timer_match;
  logic                   wr_mode;
  logic                   wr_mask;
  logic                   wr_pending;

  for (genvar i = 0; i < NUM_EXT_IRQ; i++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (ext_irq[i]),
      .q     (sync_level[i])
    );
  end

  assign wr_mode    = cfg.cfg_write && (cfg.cfg_addr == IRQ_MODE);
  assign wr_mask    = cfg.cfg_write && (cfg.cfg_addr == IRQ_MASK);
  assign wr_pending = cfg.cfg_write && (cfg.cfg_addr == IRQ_PENDING);

  // Previous synchronised level; tracked in both modes so that switching a
  // held-high line from level to edge does not look like a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_prev <= '0;
    else       sync_prev <= sync_level;
  end

  assign rise    = sync_level & ~sync_prev;
  assign w1c_ext = wr_pending ? cfg.cfg_wdata[7:1] : '0;

  // MODE and MASK registers, written by the configuration port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_ext <= '0;
      mask_q   <= '0;
    end else begin
      if (wr_mode) mode_ext <= cfg.cfg_wdata[7:1];
      if (wr_mask) mask_q   <= cfg.cfg_wdata;
    end
  end

  // External pending: level bits follow the line, edge bits latch rising
  // edges and are cleared by write-1, with a new edge beating the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_ext <= '0;
    else       pending_ext <= (mode_ext & (rise | (pending_ext & ~w1c_ext)))
                            | (~mode_ext & sync_level);
  end

`ifdef TIMER_INT_EN
  assign timer_match = (count == compare);

  // Timer pending: set on a count/compare match, cleared by any write to
  // Compare; the clear takes priority when both happen together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              pending_timer <= 1'b0;
    else if (compare_write) pending_timer <= 1'b0;
    else if (timer_match)   pending_timer <= 1'b1;
  end

  assign mask_rd = mask_q;
`else
  logic unused_timer;

  assign timer_match   = 1'b0;
  assign pending_timer = 1'b0;
  assign mask_rd       = {mask_q[7:1], 1'b0};
  assign unused_timer  = ^{count, compare, compare_write, mask_q[0]};
`endif

  assign pending_all[IRQ_EXT_BASE +: NUM_EXT_IRQ] = pending_ext;
  assign pending_all[IRQ_TIMER_BIT]               = pending_timer;

  assign interrupts = pending_all & mask_rd;

  // Register read mux, combinational from the address.
  always_comb begin
    cfg.cfg_rdata = 8'h00;
    unique case (cfg.cfg_addr)
      IRQ_MODE:    cfg.cfg_rdata = {mode_ext, 1'b0};
      IRQ_MASK:    cfg.cfg_rdata = mask_rd;
      IRQ_PENDING: cfg.cfg_rdata = pending_all;
      IRQ_RAW:     cfg.cfg_rdata = {sync_level, timer_match};
      default:     cfg.cfg_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: randomized and directed stimulus for
// interrupt_controller, scored against a cycle-indexed reference model.
// Build with or without TIMER_INT_EN; the model follows the same macro.
module tb_interrupt_controller;

  localparam int SYNC = 2;
`ifdef TIMER_INT_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] ints;
    logic [7:0] rdata;
    logic [1:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  ext_irq;
  logic [31:0] count;
  logic [31:0] compare;
  logic        compare_write;
  logic [7:0]  interrupts;

  interrupt_controller_if cfg_bus ();

  interrupt_controller #(.SYNC_STAGES(SYNC)) dut (
    .clk           (clk),
    .reset         (reset),
    .ext_irq       (ext_irq),
    .count         (count),
    .compare       (compare),
    .compare_write (compare_write),
    .cfg           (cfg_bus),
    .interrupts    (interrupts)
  );

  // Free-running clock, 20 time units per cycle.
  always #10 clk = ~clk;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  m_mode, m_mask, m_pend;
  int          edge_num   = 0;
  int          hist_floor = 0;
  logic [6:0]  hist [0:8191];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Line value that was presented before clock edge idx (0 before any reset release).
  function automatic logic [6:0] hist_at(input int idx);
    if (idx <= hist_floor || idx < 0) return 7'h00;
    return hist[idx];
  endfunction

  function automatic logic [7:0] model_read(input logic [1:0] addr);
    case (addr)
      2'd0:    return m_mode;
      2'd1:    return TIMER_ON ? m_mask : (m_mask & 8'hFE);
      2'd2:    return m_pend;
      default: return {hist_at(edge_num - SYNC + 1), TIMER_ON && (count == compare)};
    endcase
  endfunction

  // Advance the model across one clock edge, using the inputs held before it.
  task automatic model_edge();
    logic [6:0] lvl, prv, rise, w1c;
    edge_num++;
    lvl  = hist_at(edge_num - SYNC);
    prv  = hist_at(edge_num - SYNC - 1);
    rise = lvl & ~prv;
    w1c  = (cfg_bus.cfg_write && cfg_bus.cfg_addr == 2'd2) ? cfg_bus.cfg_wdata[7:1] : 7'h00;
    for (int i = 0; i < 7; i++) begin
      if (m_mode[i+1]) m_pend[i+1] = rise[i] | (m_pend[i+1] & ~w1c[i]);
      else             m_pend[i+1] = lvl[i];
    end
    if (TIMER_ON) begin
      if (compare_write)           m_pend[0] = 1'b0;
      else if (count == compare)   m_pend[0] = 1'b1;
    end else begin
      m_pend[0] = 1'b0;
    end
    if (cfg_bus.cfg_write && cfg_bus.cfg_addr == 2'd0) m_mode = {cfg_bus.cfg_wdata[7:1], 1'b0};
    if (cfg_bus.cfg_write && cfg_bus.cfg_addr == 2'd1) m_mask = cfg_bus.cfg_wdata;
  endtask

  // One clock: step the model, drive the next inputs, queue the expected outputs.
  task automatic applyStimulus(input logic [6:0] ext, input logic [31:0] cnt, input logic [31:0] cmp,
                               input logic cw, input logic wr, input logic [1:0] addr, input logic [7:0] wd);
    exp_t x;
    @(posedge clk);
    model_edge();
    #1;
    ext_irq = ext;
    count = cnt;
    compare = cmp;
    compare_write = cw;
    cfg_bus.cfg_write = wr;
    cfg_bus.cfg_addr = addr;
    cfg_bus.cfg_wdata = wd;
    hist[edge_num + 1] = ext;
    x.ints  = m_pend & m_mask;
    x.addr  = addr;
    x.rdata = model_read(addr);
    sbq.push_back(x);
  endtask

  task automatic tick(input logic [6:0] ext, input logic [1:0] addr);
    applyStimulus(ext, count, compare, 1'b0, 1'b0, addr, 8'h00);
  endtask

  task automatic wr_reg(input logic [6:0] ext, input logic [1:0] addr, input logic [7:0] d);
    applyStimulus(ext, count, compare, 1'b0, 1'b1, addr, d);
  endtask

  // With reset held: every register reads zero, RAW[0] shows the comparator.
  task automatic check_reset_state();
    checkOutput("reset_interrupts", interrupts, 8'h00);
    for (int a = 0; a < 4; a++) begin
      cfg_bus.cfg_addr = 2'(a);
      #1;
      checkOutput($sformatf("reset_rdata[%0d]", a), cfg_bus.cfg_rdata,
                  (a == 3 && TIMER_ON && count == compare) ? 8'h01 : 8'h00);
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edge_num  += 2;
    hist_floor = edge_num;
    hist[edge_num + 1] = ext_irq;
    m_mode = 8'h00;
    m_mask = 8'h00;
    m_pend = 8'h00;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_interrupts", interrupts, 8'h00);
    ext_irq = 7'h00;
    compare_write = 1'b0;
    cfg_bus.cfg_write = 1'b0;
    check_reset_state();
    release_reset();
  endtask

  // Monitor: each sampling point away from the active edge consumes one expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        checkOutput("interrupts", interrupts, x.ints);
        checkOutput($sformatf("rdata[%0d]", x.addr), cfg_bus.cfg_rdata, x.rdata);
      end
    end
  end

  // Main sequence: directed scenarios, then randomized traffic.
  initial begin
    logic [6:0]  rext, flip;
    logic [31:0] rcnt, rcmp;
    logic        rcw, rwr;

    reset = 1'b1;
    ext_irq = 7'h00;
    count = 32'd0;
    compare = 32'd0;
    compare_write = 1'b0;
    cfg_bus.cfg_write = 1'b0;
    cfg_bus.cfg_addr = 2'd0;
    cfg_bus.cfg_wdata = 8'h00;
    #3;
    check_reset_state();
    compare = 32'd1;
    release_reset();
    $display("[TB] reset released");

    // Level mode on ext_irq[2]
    wr_reg(7'h00, 2'd1, 8'hFF);
    wr_reg(7'h00, 2'd0, 8'h00);
    repeat (4) tick(7'h04, 2'd2);
    repeat (4) tick(7'h00, 2'd2);

    // Edge mode on ext_irq[0], W1C, and W1C colliding with a new edge
    wr_reg(7'h00, 2'd0, 8'h02);
    repeat (3) tick(7'h01, 2'd2);
    repeat (4) tick(7'h00, 2'd2);
    wr_reg(7'h00, 2'd2, 8'h02);
    repeat (2) tick(7'h00, 2'd2);
    tick(7'h01, 2'd2);
    tick(7'h01, 2'd2);
    wr_reg(7'h01, 2'd2, 8'h02);
    repeat (3) tick(7'h00, 2'd2);
    wr_reg(7'h00, 2'd2, 8'h02);

    // Timer: count runs through compare, then a coinciding match and clear
    applyStimulus(7'h00, 32'd90, 32'd100, 1'b1, 1'b0, 2'd2, 8'h00);
    for (int c = 91; c <= 106; c++) applyStimulus(7'h00, 32'(c), 32'd100, 1'b0, 1'b0, 2'd2, 8'h00);
    applyStimulus(7'h00, 32'd107, 32'd100, 1'b1, 1'b0, 2'd2, 8'h00);
    repeat (2) applyStimulus(7'h00, 32'd108, 32'd100, 1'b0, 1'b0, 2'd3, 8'h00);
    applyStimulus(7'h00, 32'd100, 32'd100, 1'b1, 1'b0, 2'd3, 8'h00);
    repeat (3) applyStimulus(7'h00, 32'd101, 32'd100, 1'b0, 1'b0, 2'd2, 8'h00);

    // Masking with pending = 0x0A
    wr_reg(7'h00, 2'd0, 8'h0A);
    wr_reg(7'h00, 2'd1, 8'h02);
    repeat (2) tick(7'h05, 2'd2);
    repeat (3) tick(7'h00, 2'd2);
    wr_reg(7'h00, 2'd1, 8'h00);
    repeat (2) tick(7'h00, 2'd2);
    wr_reg(7'h00, 2'd2, 8'hFF);

    // Everything pending, then asynchronous reset
    wr_reg(7'h00, 2'd0, 8'hFE);
    wr_reg(7'h00, 2'd1, 8'hFF);
    applyStimulus(7'h7F, 32'd5, 32'd5, 1'b0, 1'b0, 2'd2, 8'h00);
    repeat (3) tick(7'h7F, 2'd2);
    repeat (2) tick(7'h00, 2'd2);
    async_reset();
    $display("[TB] directed scenarios done");

    // Randomized traffic
    wr_reg(7'h00, 2'd1, 8'hFF);
    rext = 7'h00;
    for (int i = 0; i < 600; i++) begin
      flip = 7'($urandom & $urandom & $urandom);
      rext = rext ^ flip;
      rcnt = count + 32'd1;
      rcmp = compare;
      rcw  = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        rcmp = rcnt + 32'($urandom_range(0, 8));
        rcw  = 1'b1;
      end
      rwr = ($urandom_range(0, 3) == 0);
      applyStimulus(rext, rcnt, rcmp, rcw, rwr, 2'($urandom_range(0, 3)), 8'($urandom));
      if (i == 300) begin
        async_reset();
        wr_reg(rext, 2'd1, 8'hFF);
      end
    end

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drain", 8'(sbq.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Upstream interrupt front-end for coprocessor 0. It synchronises seven asynchronous external interrupt lines, applies per-line edge/level capture and masking, and generates the count/compare timer interrupt. It drives the 8-bit `interrupts` vector consumed by the CP0 exception unit, with the timer on bit 0 and external lines on bits 7:1. The CPU reaches its registers through a small configuration port, which is decoded by the CP0 glue.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops per external line; legal values are 2 and above.

Ports:
- clk  in  1  single clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ext_irq  in  7  asynchronous external lines; ext_irq[i] maps to interrupts[i+1].
- count  in  32  CP0 Count value.
- compare  in  32  CP0 Compare value.
- compare_write  in  1  one-cycle pulse on every MTC0 to Compare (reg 11).
- cfg_write  in  1  register write strobe.
- cfg_addr  in  2  register select: 0 MODE, 1 MASK, 2 PENDING, 3 RAW.
- cfg_wdata  in  8  write data.
- cfg_rdata  out  8  read data; combinational from cfg_addr.
- interrupts  out  8  PENDING & MASK; feeds CP0.

## Operation
- Synchronizer: each ext_irq[i] passes through a SYNC_STAGES flop chain. Its output s[i] is the line's synchronised level.
- MODE[7:1]: 1 selects edge capture, 0 selects level. MODE[0] is read-only 0. Reset value 0x00.
- MASK[7:0]: read/write. Reset value 0x00, so interrupts = 0 out of reset.
- PENDING, external bits in level mode:
  - pending[i+1] <= s[i] every cycle.
  - Writes have no effect.
- PENDING, external bits in edge mode:
  - pending is set when s[i]=1 and s_prev[i]=0.
  - It is cleared by writing 1 to that bit of PENDING (write-1-to-clear). Writing 0 has no effect.
  - If a set and a clear land in the same cycle, the set wins.
- Timer bit, pending[0]:
  - Set on any cycle where count == compare (full 32-bit equality).
  - Cleared on compare_write.
  - If a match and compare_write coincide, the clear wins.
  - Writes to PENDING[0] are ignored.
- MODE change: the s_prev edge register keeps updating in both modes. Switching level→edge with the line held high does not generate an edge.
- RAW (read-only): {s[6:0], count==compare}. Writes to it are ignored.
- Writes to addresses 0 and 1 take effect at the next clock edge.
- Reset mid-operation clears all synchronizer flops, s_prev, MODE, MASK and PENDING immediately. interrupts goes to 0 asynchronously.

## Timing
- External line, both modes: ext_irq high before edge k makes pending visible after edge k+SYNC_STAGES. That is 2 cycles at the default setting.
- Edge-mode release: a line that drops leaves pending set until software clears it.
- Level-mode release: pending follows the line's fall with the same latency as its rise.
- Timer: a match in cycle k makes interrupts[0] (if masked in) high after edge k+1. It stays high across later mismatches until compare_write.
- W1C: a write at edge k clears pending at edge k, so interrupts drops in cycle k+1.
- The mask path is combinational: interrupts reflects a MASK write one cycle after the strobe edge.
- Reset values: interrupts = 0x00. cfg_rdata = 0x00 for every address, except RAW bit 0, which shows count==compare.

## Configuration
- TIMER_INT_EN defined: the timer logic described above is present.
- TIMER_INT_EN undefined:
  - pending[0], interrupts[0], RAW[0] and the MASK[0] read-back are all constant 0.
  - count, compare and compare_write are unused.
  - No comparator is synthesised.

## Structure
- Shared package irq_pkg holds:
  - register address constants IRQ_MODE=0, IRQ_MASK=1, IRQ_PENDING=2, IRQ_RAW=3;
  - IRQ_TIMER_BIT=0 and IRQ_EXT_BASE=1;
  - NUM_EXT_IRQ=7.
- One sub-module, irq_sync: a parameterised SYNC_STAGES flop chain with asynchronous reset, instantiated once per external line.

## Test plan
- Reset, then level mode with MASK=0xFF: raise ext_irq[2] before edge 0 → interrupts = 0x08 after edge 2; drop the line → 0x00 two edges later.
- Edge mode (MODE=0x02) on ext_irq[0], pulsed high 3 cycles → interrupts[1] stays 1 after the line falls. Write PENDING=0x02 → it clears. Write PENDING=0x02 in the same cycle as a new edge → bit stays 1.
- Timer: compare=100, count counting → interrupts[0] rises the cycle after count=100, holds through 101..105, clears after compare_write. Then count==compare together with compare_write → stays 0.
- Masking: pending=0x0A with MASK=0x02 → interrupts = 0x02. Write MASK=0x00 → interrupts = 0x00 while PENDING still reads 0x0A.
- Assert reset asynchronously while pending=0xFF → interrupts = 0x00 before the next clock edge; MODE, MASK and PENDING read 0.
- Build without TIMER_INT_EN: count==compare → interrupts[0], RAW[0] and PENDING[0] remain 0.
